// File: rtl/muldiv_unit_pkg.sv
// Shared pipeline types for the EX-stage HI/LO multiply/divide unit.
package pipTypes;

  typedef enum logic [2:0] {
    OP_MUL  = 3'd0,
    OP_DIV  = 3'd1,
    OP_MTHI = 3'd2,
    OP_MTLO = 3'd3,
    OP_MFHI = 3'd4,
    OP_MFLO = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_MUL   = 2'd1,
    MD_DIV   = 2'd2,
    MD_FIXUP = 2'd3
  } muldiv_state_t;

  localparam int MULDIV_ITERS = 32;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-divide step: shift in the next dividend bit, subtract the divisor if it fits.
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {2'b00, divisor});
    diff    = shifted[WIDTH:0] - {1'b0, divisor};
    rem_out = q_bit ? diff : shifted[WIDTH:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit (shift-add multiply, restoring divide).
// Optional MULDIV_EARLY_OUT_EN: multiply stops once the remaining multiplier bits are zero.
module muldiv_unit
  import pipTypes::*;
#(
  parameter int WIDTH = MULDIV_ITERS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  muldiv_op_t       req_op,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  // Handshake: a request transfers on a rising edge with req_valid & req_ready & ~flush;
  // req_ready is high only in IDLE and never depends on req_valid.
  muldiv_state_t      state;
  logic [CW-1:0]      iter;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   raw_a;
  logic [WIDTH:0]     rem;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  logic               is_div;

  logic               accept;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [2*WIDTH-1:0] mul_add;
  logic [WIDTH-1:0]   mplier_next;
  logic               mul_last;
  logic               div_last;
  logic [WIDTH:0]     rem_nx;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   remd;

  assign req_ready = (state == MD_IDLE);
  assign busy      = (state != MD_IDLE);
  assign dbg_state = state;
  assign accept    = req_valid & req_ready & ~flush;

  always_comb begin
    a_neg       = ~req_unsigned & a[WIDTH-1];
    b_neg       = ~req_unsigned & b[WIDTH-1];
    a_abs       = a_neg ? -a : a;
    b_abs       = b_neg ? -b : b;
    mul_add     = mplier[0] ? (acc + mcand) : acc;
    mplier_next = mplier >> 1;
`ifdef MULDIV_EARLY_OUT_EN
    mul_last    = (mplier_next == '0) || (iter == CW'(WIDTH - 1));
`else
    mul_last    = (iter == CW'(WIDTH - 1));
`endif
    div_last    = (iter == CW'(WIDTH - 1));
    prod        = neg_q ? -acc : acc;
    quot        = neg_q ? -dvd : dvd;
    remd        = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (rem),
    .divisor (divisor),
    .bit_in  (dvd[WIDTH-1]),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= MD_IDLE;
      iter     <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      dvd      <= '0;
      divisor  <= '0;
      raw_a    <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      is_div   <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (accept) begin
            case (req_op)
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              OP_MUL: begin
                state  <= MD_MUL;
                iter   <= '0;
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, a_abs};
                mplier <= b_abs;
                neg_q  <= a_neg ^ b_neg;
                is_div <= 1'b0;
              end
              OP_DIV: begin
                state    <= MD_DIV;
                iter     <= '0;
                rem      <= '0;
                dvd      <= a_abs;
                divisor  <= b_abs;
                raw_a    <= a;
                div_zero <= (b == '0);
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                is_div   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        MD_MUL: begin
          if (flush) begin
            state <= MD_IDLE;
            iter  <= '0;
          end else begin
            acc    <= mul_add;
            mcand  <= mcand << 1;
            mplier <= mplier_next;
            iter   <= iter + CW'(1);
            if (mul_last) begin
              state <= MD_FIXUP;
              iter  <= '0;
            end
          end
        end
        MD_DIV: begin
          if (flush) begin
            state <= MD_IDLE;
            iter  <= '0;
          end else begin
            rem  <= rem_nx;
            dvd  <= {dvd[WIDTH-2:0], q_bit};
            iter <= iter + CW'(1);
            if (div_last) begin
              state <= MD_FIXUP;
              iter  <= '0;
            end
          end
        end
        MD_FIXUP: begin
          // hi/lo change only here, so EX never sees a partial result.
          state <= MD_IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              if (div_zero) begin
                lo <= '1;
                hi <= raw_a;
              end else begin
                lo <= quot;
                hi <= remd;
              end
            end else begin
              {hi, lo} <= prod;
            end
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle HI/LO multiply/divide responder for the EX stage.
- EX issues mul/div/mthi/mtlo requests over a valid/ready handshake.
- The unit computes iteratively (shift-add multiply, restoring divide), then commits the architectural HI/LO registers.
- Replaces the combinational "*", "/" and "%" path with synthesizable logic; EX stalls on busy before reading hi/lo.

Parameters:
WIDTH, 32, operand width and HI/LO register width; iteration count equals WIDTH.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  EX presents a muldiv request
req_ready  out  1  unit can accept a request this cycle
req_op  in  muldiv_op_t  OP_MUL, OP_DIV, OP_MTHI, OP_MTLO; any other value is ignored
req_unsigned  in  1  1 = multu/divu, 0 = signed
a  in  WIDTH  forwarded rs value (multiplicand/dividend; mthi/mtlo source)
b  in  WIDTH  forwarded rt value (multiplier/divisor)
flush  in  1  abort the in-flight operation (branch mispredict/exception)
busy  out  1  MUL/DIV in progress; EX must stall mfhi/mflo and new requests
done  out  1  one-cycle pulse: MUL/DIV result committed to hi/lo
hi  out  WIDTH  architectural HI register
lo  out  WIDTH  architectural LO register

Behaviour:
- Reset state:
  - hi = 0, lo = 0
  - busy = 0, done = 0, req_ready = 1
  - FSM = IDLE, iteration counter = 0
- Handshake:
  - A request is accepted on a rising edge where req_valid & req_ready & ~flush.
  - req_ready = (state == IDLE).
  - a, b and req_unsigned are captured at the accept edge; later changes are ignored.
- MTHI/MTLO:
  - hi (or lo) <= a at the accept edge.
  - No busy, no done; FSM stays in IDLE.
- FSM states:
  - IDLE -> MUL or DIV on accept of OP_MUL/OP_DIV.
  - MUL/DIV -> FIXUP after WIDTH iterations (counter 0..WIDTH-1).
  - FIXUP -> IDLE.
  - Any non-IDLE state -> IDLE on flush.
- Signed handling:
  - Accept edge stores |a|, |b| and sign flags.
  - FIXUP applies the sign rules:
    - product negated (2*WIDTH bits) if the signs differ
    - quotient negated if the signs differ
    - remainder takes the sign of the dividend
  - Unsigned operations skip negation; FIXUP still costs one cycle.
- Multiply:
  - One bit of |b| per cycle, LSB first.
  - 2*WIDTH-bit accumulator, shift-add.
  - {hi, lo} <= product.
- Divide:
  - Restoring, one quotient bit per cycle, MSB first.
  - WIDTH+1-bit partial remainder.
  - lo <= quotient, hi <= remainder.
- Latency:
  - Accept at edge 0.
  - Iterations on edges 1..32; FIXUP on edge 33, which writes hi/lo and raises done.
  - done is high during the cycle after edge 33, exactly one cycle; busy drops on the same edge.
  - Next request is accepted no earlier than edge 34.
- hi/lo hold their old values throughout MUL/DIV; they are never partially updated.
- Divide by zero:
  - lo = all ones, hi = raw a, regardless of signedness.
  - No exception.
- Signed overflow: -2^31 / -1 gives lo = 0x80000000, hi = 0.
- Flush:
  - Aborts on its edge; hi/lo unchanged, no done, FSM -> IDLE.
  - A request presented in the same cycle as flush is not accepted.
  - Flush while IDLE has no effect.
- Reset asserted mid-operation forces the full reset state immediately (asynchronous).

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined:
  - MUL terminates iteration once the remaining multiplier bits are all zero (minimum one iteration).
  - Latency = (significant bits of |b|, min 1) + 2 cycles to done.
  - DIV is unchanged.
- Undefined: fixed 34-cycle latency for MUL and DIV as above.

Decomposition:
- pipTypes already holds muldiv_op_t (OP_MUL, OP_DIV, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO).
- Add muldiv_state_t {MD_IDLE, MD_MUL, MD_DIV, MD_FIXUP} and MULDIV_ITERS = 32 to pipTypes.
- One sub-module, muldiv_div_step: combinational single restoring-divide step.
  - In: partial remainder, divisor, next dividend bit.
  - Out: new remainder, quotient bit.

Test Plan:
- MTHI a=0xDEADBEEF, then MTLO a=0x12345678 on back-to-back cycles -> hi=0xDEADBEEF, lo=0x12345678 one edge after each accept; busy stays 0.
- Signed MUL a=-3 (0xFFFFFFFD), b=7 -> done 34 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFEB; hi/lo unchanged until done.
- Unsigned MUL a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100.
- DIV a=0x80000000, b=0xFFFFFFFF signed -> lo=0x80000000, hi=0. Request held during busy -> req_ready=0, not accepted until after done.
- Start MUL, assert flush at cycle 10 with a new req_valid -> no done, hi/lo retain prior values, req_ready=1 the next cycle. With MULDIV_EARLY_OUT_EN, MUL a=3, b=5 -> done after 5 cycles, lo=15.
